// File: rtl/uart_tx_frame_ctrl.sv
// UART transmit frame controller: start, LSB-first data,
// optional parity and stop bit, one bit per clk.
module uart_tx_frame_ctrl #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  Data_valid,
   input  logic [DATA_WIDTH-1:0] P_Data,
   input  logic                  Par_en,
   input  logic                  Par_bit,
   output logic                  TX_OUT,
   output logic                  Busy
);

   localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   state_t                state;
   logic [DATA_WIDTH-1:0] shreg;
   logic [CW-1:0]         cnt;
   logic                  par_en_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         shreg    <= '0;
         cnt      <= '0;
         par_en_q <= 1'b0;
         TX_OUT   <= 1'b1;
         Busy     <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               TX_OUT <= 1'b1;
               Busy   <= 1'b0;
               if (Data_valid && !Busy) begin
                  shreg    <= P_Data;
                  par_en_q <= Par_en;
                  cnt      <= '0;
                  state    <= START;
                  TX_OUT   <= 1'b0;
                  Busy     <= 1'b1;
               end
            end
            START: begin
               state  <= DATA;
               TX_OUT <= shreg[0];
               shreg  <= shreg >> 1;
               cnt    <= '0;
            end
            DATA: begin
               // bit 0 already left on the START edge, so the last
               // counter value hands over to parity/stop
               if (cnt == LAST) begin
                  if (par_en_q) begin
                     state  <= PARITY;
                     TX_OUT <= Par_bit;
                  end else begin
                     state  <= STOP;
                     TX_OUT <= 1'b1;
                  end
               end else begin
                  TX_OUT <= shreg[0];
                  shreg  <= shreg >> 1;
                  cnt    <= cnt + CW'(1);
               end
            end
            PARITY: begin
               state  <= STOP;
               TX_OUT <= 1'b1;
            end
            STOP: begin
               state  <= IDLE;
               TX_OUT <= 1'b1;
               Busy   <= 1'b0;
            end
            default: begin
               state  <= IDLE;
               TX_OUT <= 1'b1;
               Busy   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// Scoreboard bench for uart_tx_frame_ctrl: expected
// {TX_OUT,Busy} per cycle queued at accept, checked each negedge.
module tb_uart_tx_frame_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       Data_valid;
   logic [7:0] P_Data;
   logic       Par_en;
   logic       Par_bit;
   logic       TX_OUT;
   logic       Busy;

   logic [1:0] exp_q[$];
   logic       mon_en = 1'b0;
   int         n_chk = 0;
   int         n_err = 0;

   always #5 clk = ~clk;

   uart_tx_frame_ctrl #(.DATA_WIDTH(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .Data_valid (Data_valid),
      .P_Data     (P_Data),
      .Par_en     (Par_en),
      .Par_bit    (Par_bit),
      .TX_OUT     (TX_OUT),
      .Busy       (Busy)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // {tx, busy} per line cycle following the accept edge
   task automatic push_frame(input logic [7:0] d, input logic pe,
                             input logic pb);
      exp_q.push_back(2'b01);
      for (int i = 0; i < 8; i++) exp_q.push_back({d[i], 1'b1});
      if (pe) exp_q.push_back({pb, 1'b1});
      exp_q.push_back(2'b11);
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         if (exp_q.size() > 0) chk("line", {TX_OUT, Busy}, exp_q.pop_front());
         else chk("idle", {TX_OUT, Busy}, 2'b10);
      end
   end

   task automatic send(input logic [7:0] d, input logic pe,
                       input logic odd);
      logic pb;
      pb = (^d) ^ odd;
      @(posedge clk);
      #1;
      Data_valid = 1'b1;
      P_Data     = d;
      Par_en     = pe;
      @(posedge clk);
      push_frame(d, pe, pb);
      #1;
      Data_valid = 1'b0;
      Par_bit    = pb;
   endtask

   initial begin
      rst        = 1'b0;
      Data_valid = 1'b0;
      P_Data     = '0;
      Par_en     = 1'b0;
      Par_bit    = 1'b0;
      #12;
      chk("rst_tx", TX_OUT, 1'b1);
      chk("rst_busy", Busy, 1'b0);
      @(posedge clk);
      #1;
      rst    = 1'b1;
      mon_en = 1'b1;

      send(8'hA5, 1'b1, 1'b0);
      repeat (13) @(posedge clk);
      send(8'h01, 1'b1, 1'b1);
      repeat (13) @(posedge clk);
      send(8'hFF, 1'b0, 1'b0);
      repeat (13) @(posedge clk);

      // Data_valid held across two frames, inputs change mid-frame
      @(posedge clk);
      #1;
      Data_valid = 1'b1;
      P_Data     = 8'h3C;
      Par_en     = 1'b0;
      @(posedge clk);
      push_frame(8'h3C, 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      P_Data  = 8'hC3;
      Par_en  = 1'b1;
      Par_bit = 1'b1;
      repeat (8) @(posedge clk);
      push_frame(8'hC3, 1'b1, 1'b1);
      #1;
      Data_valid = 1'b0;
      repeat (14) @(posedge clk);

      // request pulse during a frame is ignored
      send(8'h5A, 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      Data_valid = 1'b1;
      P_Data     = 8'hFF;
      Par_en     = 1'b1;
      @(posedge clk);
      #1;
      Data_valid = 1'b0;
      repeat (14) @(posedge clk);

      // async reset mid-frame
      send(8'hC3, 1'b1, 1'b0);
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b0;
      exp_q.delete();
      #1;
      chk("mid_rst_tx", TX_OUT, 1'b1);
      chk("mid_rst_busy", Busy, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      send(8'h55, 1'b1, 1'b0);
      repeat (14) @(posedge clk);

      chk("q_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
